cla_sum_collector: RTL and testbench
====================================

// Module: cla_sum_collector
// PURPOSE
//   Downstream consumer of the registered 4-bit CLA stage: takes one S nibble
//   (plus cout) per accepted beat and packs NIBBLES beats, LSB nibble first,
//   into one wide result word with carry flag.
//   Two-slot buffering (assembly + output register) provides full throughput
//   with valid/ready backpressure toward the result sink.
// PARAMETERS
//   NIBBLES  4  nibbles per output word (>=2); word width W = 4*NIBBLES
// PORTS
//   clk        in   1  rising-edge clock, shared with the adder stage
//   rst        in   1  synchronous reset, active-high
//   in_valid   in   1  in_s/in_cout carry a valid adder result this cycle
//   in_s       in   4  sum nibble from adder output register
//   in_cout    in   1  carry-out from adder output register
//   in_ready   out  1  collector accepts a beat this cycle
//   out_valid  out  1  out_word/out_carry hold a complete word
//   out_ready  in   1  sink accepts the word this cycle
//   out_word   out  W  assembled sum, nibble k at bits [4k+3:4k]
//   out_carry  out  1  in_cout of the word's final (most significant) nibble
// BEHAVIOUR
// - Accept = in_valid & in_ready; drain = out_valid & out_ready (both sampled at posedge).
// - State: asm_word (W), asm_idx (0..NIBBLES-1), asm_full; out regs, out_valid.
// - in_ready = ~asm_full & ~rst (combinational from regs; no path from in_valid).
// - Reset: out_valid=0, out_word=0, out_carry=0, asm_idx=0, asm_full=0,
//   asm_word=0; in_ready=0 while rst high, 1 first cycle after.
// - Reset mid-word discards partial nibbles; next accept is nibble 0.
// - Accept, asm_idx<NIBBLES-1: asm_word[4*idx+:4]<=in_s; idx++. in_cout ignored.
// - Accept, asm_idx==NIBBLES-1 (final): word = {in_s, asm_word lower}; idx<=0;
//   carry = in_cout.
//   - if ~out_valid | out_ready: out_word<=word, out_carry<=carry, out_valid<=1
//     next cycle (latency 1 clock final beat -> out_valid).
//   - else: asm_word<=word, stored carry<=carry, asm_full<=1.
// - asm_full & (~out_valid | out_ready): out <= asm contents, out_valid<=1,
//   asm_full<=0; in_ready returns next cycle.
// - Drain with no pending word: out_valid<=0; out_word/out_carry hold value.
// - Simultaneous drain + final accept: new word replaces old, out_valid stays 1,
//   no bubble. Max 2 complete words held; words leave strictly in order.
// - out_word/out_carry stable while out_valid & ~out_ready.
// - in_valid gaps allowed between nibbles; idx only advances on accept.
// - No arithmetic here: nibbles concatenated, intermediate couts dropped
//   (upstream already chained them via cin).
// TESTING (NIBBLES=4)
// - Beats 0x1,0x2,0x3,0x4 (cout 0,0,0,1), out_ready=1 -> next clock
//   out_valid=1, out_word=0x4321, out_carry=1; following clock out_valid=0.
// - Back-to-back words A=0xF,0xE,0xD,0xC, B=0x0..0x3, out_ready=1 ->
//   0xCDEF then 0x3210 on consecutive word slots, in_ready never low.
// - out_ready=0, two words fed -> 2nd final beat sets asm_full, in_ready=0,
//   extra in_valid beats ignored; raise out_ready -> 1st word, then 2nd next
//   cycle, in_ready=1 after.
// - Final nibble same cycle as drain of held word -> out_valid stays 1,
//   out_word switches to new value in one clock.
// - 2 nibbles (0x9,0x8) then rst 1 cycle, then 0x5,0x6,0x7,0x8 -> 0x8765,
//   out_valid=0 and out_word=0 during/after reset until then.
// - in_valid toggled 1/0 per cycle with nibbles 0xA,0xB,0xC,0xD -> 0xDCBA.

Source files
------------

// File: rtl/cla_sum_collector.sv
// Collects 4-bit sum nibbles from the registered CLA stage and packs
// NIBBLES of them, least significant nibble first, into one wide word.
// The carry flag of a word is the cout of its most significant nibble.
// An assembly slot plus an output register give two words of storage,
// so the sink may stall for a full word without stopping the adder stream.
module cla_sum_collector #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  input  logic [3:0]             in_s_i,
  input  logic                   in_cout_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [4*NIBBLES-1:0]   out_word_o,
  output logic                   out_carry_o
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Assembly slot: partial word while filling, complete word while asm_full_q.
  logic [W-1:0]     asm_word_q, asm_word_d;
  logic [IDX_W-1:0] asm_idx_q,  asm_idx_d;
  logic             asm_full_q, asm_full_d;
  logic             asm_carry_q, asm_carry_d;

  // Output register presented to the sink.
  logic [W-1:0]     out_word_q, out_word_d;
  logic             out_carry_q, out_carry_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             out_free;
  logic             final_beat;
  logic [W-1:0]     final_word;

  // Ready depends only on registered state and reset, never on in_valid_i.
  assign in_ready_o  = ~asm_full_q & ~rst_i;
  assign accept      = in_valid_i & in_ready_o;
  assign out_free    = ~out_valid_q | out_ready_i;
  assign final_beat  = (asm_idx_q == IDX_LAST);
  assign final_word  = {in_s_i, asm_word_q[W-5:0]};

  assign out_valid_o = out_valid_q;
  assign out_word_o  = out_word_q;
  assign out_carry_o = out_carry_q;

  // Next-state for assembly slot and output register.
  always_comb begin
    asm_word_d  = asm_word_q;
    asm_idx_d   = asm_idx_q;
    asm_full_d  = asm_full_q;
    asm_carry_d = asm_carry_q;
    out_word_d  = out_word_q;
    out_carry_d = out_carry_q;
    // A drain with nothing to replace it empties the output; data holds.
    out_valid_d = out_valid_q & ~out_ready_i;

    if (asm_full_q) begin
      // Held word moves up as soon as the output slot frees; no accept can
      // happen this cycle because in_ready_o is low.
      if (out_free) begin
        out_word_d  = asm_word_q;
        out_carry_d = asm_carry_q;
        out_valid_d = 1'b1;
        asm_full_d  = 1'b0;
      end
    end else if (accept) begin
      if (final_beat) begin
        asm_idx_d = '0;
        if (out_free) begin
          // Covers the simultaneous drain case: new word replaces old, no bubble.
          out_word_d  = final_word;
          out_carry_d = in_cout_i;
          out_valid_d = 1'b1;
        end else begin
          asm_word_d  = final_word;
          asm_carry_d = in_cout_i;
          asm_full_d  = 1'b1;
        end
      end else begin
        // Intermediate couts are already folded in upstream via cin.
        asm_word_d[{asm_idx_q, 2'b00} +: 4] = in_s_i;
        asm_idx_d = asm_idx_q + IDX_ONE;
      end
    end
  end

  // State registers with synchronous reset; reset drops any partial word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      asm_word_q  <= '0;
      asm_idx_q   <= '0;
      asm_full_q  <= 1'b0;
      asm_carry_q <= 1'b0;
      out_word_q  <= '0;
      out_carry_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      asm_word_q  <= asm_word_d;
      asm_idx_q   <= asm_idx_d;
      asm_full_q  <= asm_full_d;
      asm_carry_q <= asm_carry_d;
      out_word_q  <= out_word_d;
      out_carry_q <= out_carry_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_cla_sum_collector.sv
// Directed bench for cla_sum_collector with NIBBLES=4.
module tb_cla_sum_collector;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_s;
  logic        in_cout;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic        out_carry;

  int n_checks = 0;
  int n_fail   = 0;

  cla_sum_collector #(.NIBBLES(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_s_i      (in_s),
    .in_cout_i   (in_cout),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_word_o  (out_word),
    .out_carry_o (out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] s, input logic c);
    in_valid = 1'b1;
    in_s     = s;
    in_cout  = c;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_s = 4'h0; in_cout = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_word !== 16'h0000 || out_carry !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_data: got %h/%b want 0000/0", out_word, out_carry);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    beat(4'h1, 1'b0); beat(4'h2, 1'b0); beat(4'h3, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    beat(4'h4, 1'b1);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 16'h4321 || out_carry !== 1'b1) begin
      n_fail++; $display("FAIL basic_word: got v=%b %h c=%b want v=1 4321 c=1", out_valid, out_word, out_carry);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] nib [8];
    logic       cts [8];
    int         ready_low;
    nib = '{4'hF, 4'hE, 4'hD, 4'hC, 4'h0, 4'h1, 4'h2, 4'h3};
    cts = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ready_low = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (in_ready !== 1'b1) ready_low++;
      beat(nib[i], cts[i]);
      if (i == 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_word !== 16'hCDEF || out_carry !== 1'b0) begin
          n_fail++; $display("FAIL b2b_word_a: got v=%b %h c=%b want v=1 cdef c=0", out_valid, out_word, out_carry);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 16'h3210 || out_carry !== 1'b1) begin
      n_fail++; $display("FAIL b2b_word_b: got v=%b %h c=%b want v=1 3210 c=1", out_valid, out_word, out_carry);
    end
    n_checks++;
    if (ready_low !== 0) begin n_fail++; $display("FAIL b2b_in_ready: low %0d cycles want 0", ready_low); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(4'h5, 1'b0); beat(4'h6, 1'b0); beat(4'h7, 1'b0); beat(4'h8, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 16'h8765) begin
      n_fail++; $display("FAIL bp_first_word: got v=%b %h want v=1 8765", out_valid, out_word);
    end
    beat(4'h9, 1'b1); beat(4'hA, 1'b1); beat(4'hB, 1'b1); beat(4'hC, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_asm_full_ready: got %b want 0", in_ready); end
    beat(4'hF, 1'b1); beat(4'hF, 1'b1);
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 16'h8765 || out_carry !== 1'b1) begin
      n_fail++; $display("FAIL bp_stall_hold: got rdy=%b v=%b %h c=%b want rdy=0 v=1 8765 c=1",
                         in_ready, out_valid, out_word, out_carry);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 16'hCBA9 || out_carry !== 1'b0) begin
      n_fail++; $display("FAIL bp_second_word: got v=%b %h c=%b want v=1 cba9 c=0", out_valid, out_word, out_carry);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return: got %b want 1", in_ready); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_overlap();
    out_ready = 1'b0;
    beat(4'h1, 1'b0); beat(4'h2, 1'b0); beat(4'h3, 1'b0); beat(4'h4, 1'b0);
    beat(4'hD, 1'b0); beat(4'hE, 1'b0); beat(4'hF, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 16'h4321 || out_carry !== 1'b0) begin
      n_fail++; $display("FAIL ovl_held: got v=%b %h c=%b want v=1 4321 c=0", out_valid, out_word, out_carry);
    end
    out_ready = 1'b1;
    beat(4'h0, 1'b1);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 16'h0FED || out_carry !== 1'b1) begin
      n_fail++; $display("FAIL ovl_switch: got v=%b %h c=%b want v=1 0fed c=1", out_valid, out_word, out_carry);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovl_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b1;
    beat(4'h9, 1'b0); beat(4'h8, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_rst: got %b want 0", in_ready); end
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_word !== 16'h0000) begin
      n_fail++; $display("FAIL rmid_after_rst: got v=%b %h want v=0 0000", out_valid, out_word);
    end
    beat(4'h5, 1'b0); beat(4'h6, 1'b0); beat(4'h7, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_word !== 16'h0000) begin
      n_fail++; $display("FAIL rmid_partial: got v=%b %h want v=0 0000", out_valid, out_word);
    end
    beat(4'h8, 1'b0);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 16'h8765 || out_carry !== 1'b0) begin
      n_fail++; $display("FAIL rmid_word: got v=%b %h c=%b want v=1 8765 c=0", out_valid, out_word, out_carry);
    end
    tick();
  endtask

  task automatic test_gappy();
    logic [3:0] nib [4];
    nib = '{4'hA, 4'hB, 4'hC, 4'hD};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(nib[i], 1'b1);
      if (i == 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_word !== 16'hDCBA || out_carry !== 1'b1) begin
          n_fail++; $display("FAIL gap_word: got v=%b %h c=%b want v=1 dcba c=1", out_valid, out_word, out_carry);
        end
      end else begin
        in_valid = 1'b0;
        in_s     = 4'h0;
        in_cout  = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid_%0d: got %b want 0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_overlap();
    test_reset_mid_word();
    test_gappy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
